// File: rtl/cra_next_addr_if.sv
// Bus between the IR board / microsequencer and the CRAM next-address stage.
// master: drives the dispatch inputs and strobes, observes the address and stack status.
// slave:  the next-address stage itself.
// Signals:
//   cramAdvance, CRAM_J, CRAM_DISP, CRAM_CALL    - current microword control
//   DRAM_J, DRAM_A, DRAM_B, norm, testSatisfied  - IR board dispatch sources
//   diagLoadAdr, diagAdr                         - diagnostic address force-load
//   CRA_ADR, stackDepth, stackErr                - registered address and stack status
interface cra_next_addr_if #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned ADR_W       = 11
);
    logic                             cramAdvance;
    logic [ADR_W-1:0]                 CRAM_J;
    logic [2:0]                       CRAM_DISP;
    logic                             CRAM_CALL;
    logic [ADR_W-1:0]                 DRAM_J;
    logic [2:0]                       DRAM_A;
    logic [2:0]                       DRAM_B;
    logic [2:0]                       norm;
    logic                             testSatisfied;
    logic                             diagLoadAdr;
    logic [ADR_W-1:0]                 diagAdr;
    logic [ADR_W-1:0]                 CRA_ADR;
    logic [$clog2(STACK_DEPTH):0]     stackDepth;
    logic                             stackErr;

    modport master (
        output cramAdvance, CRAM_J, CRAM_DISP, CRAM_CALL, DRAM_J, DRAM_A, DRAM_B, norm,
               testSatisfied, diagLoadAdr, diagAdr,
        input  CRA_ADR, stackDepth, stackErr
    );

    modport slave (
        input  cramAdvance, CRAM_J, CRAM_DISP, CRAM_CALL, DRAM_J, DRAM_A, DRAM_B, norm,
               testSatisfied, diagLoadAdr, diagAdr,
        output CRA_ADR, stackDepth, stackErr
    );
endinterface

// File: rtl/cra_next_addr.sv
// Control-RAM next-address stage. Selects the next microword address from the current
// microword's jump field and the IR board's dispatch sources, registers it, and keeps a
// microcode call/return stack.
// Ports:
//   clk    - system clock
//   resetN - synchronous active-low reset
//   bus    - cra_next_addr_if.slave (dispatch inputs in, CRA_ADR / stack status out)
module cra_next_addr #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned ADR_W       = 11
) (
    input logic              clk,
    input logic              resetN,
    cra_next_addr_if.slave   bus
);
    localparam int unsigned PtrW   = $clog2(STACK_DEPTH);
    localparam int unsigned DepthW = PtrW + 1;

    localparam logic [2:0] DispJump  = 3'd0;
    localparam logic [2:0] DispDramJ = 3'd1;
    localparam logic [2:0] DispDramA = 3'd2;
    localparam logic [2:0] DispDramB = 3'd3;
    localparam logic [2:0] DispNorm  = 3'd4;
    localparam logic [2:0] DispTest  = 3'd5;
    localparam logic [2:0] DispRet   = 3'd6;

    logic [ADR_W-1:0]  cra_adr_q, cra_adr_d;
    logic [DepthW-1:0] depth_q, depth_d;
    logic              err_q, err_d;
    logic [ADR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADR_W-1:0]  stack_d [STACK_DEPTH];

    logic              is_ret, empty, underflow, do_pop, overflow, push_ok, push_we;
    logic [DepthW-1:0] depth_popped;
    logic [PtrW-1:0]   top_idx;
    logic [ADR_W-1:0]  top_val, next_adr;

    // Stack bookkeeping: a pop (if any) happens before the push, so a same-cycle
    // call+return reuses the freed slot and never overflows.
    always_comb begin
        is_ret       = (bus.CRAM_DISP == DispRet);
        empty        = (depth_q == '0);
        underflow    = is_ret & empty;
        do_pop       = is_ret & ~empty;
        depth_popped = depth_q - DepthW'(do_pop);
        overflow     = bus.CRAM_CALL & (depth_popped == DepthW'(STACK_DEPTH));
        push_ok      = bus.CRAM_CALL & ~overflow;
        // Index is garbage when empty, but the value is only used when non-empty.
        top_idx      = PtrW'(depth_q - DepthW'(1));
        top_val      = stack_q[top_idx];
        push_we      = resetN & ~bus.diagLoadAdr & bus.cramAdvance & push_ok;
    end

    // Next-address select; all modifiers are pure OR into the jump field.
    always_comb begin
        next_adr = bus.CRAM_J;
        case (bus.CRAM_DISP)
            DispJump:  next_adr = bus.CRAM_J;
            DispDramJ: next_adr = bus.DRAM_J;
            DispDramA: next_adr = bus.CRAM_J | ADR_W'(bus.DRAM_A);
            DispDramB: next_adr = bus.CRAM_J | ADR_W'(bus.DRAM_B);
            DispNorm:  next_adr = bus.CRAM_J | ADR_W'(bus.norm);
            DispTest:  next_adr = bus.CRAM_J | ADR_W'(bus.testSatisfied);
            DispRet:   next_adr = underflow ? bus.CRAM_J : (top_val | bus.CRAM_J);
            default:   next_adr = bus.CRAM_J;
        endcase
    end

    always_comb begin
        cra_adr_d = cra_adr_q;
        depth_d   = depth_q;
        err_d     = err_q;
        if (bus.diagLoadAdr) begin
            cra_adr_d = bus.diagAdr;
        end else if (bus.cramAdvance) begin
            cra_adr_d = next_adr;
            depth_d   = depth_popped + DepthW'(push_ok);
            err_d     = err_q | underflow | overflow;
        end
    end

    // The calling word's own address is pushed, not the jump target.
    always_comb begin
        stack_d = stack_q;
        if (push_we) begin
            stack_d[depth_popped[PtrW-1:0]] = cra_adr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cra_adr_q <= '0;
            depth_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            cra_adr_q <= cra_adr_d;
            depth_q   <= depth_d;
            err_q     <= err_d;
        end
    end

    // Stack contents need no reset: entries at or beyond depth are never read.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.CRA_ADR    = cra_adr_q;
    assign bus.stackDepth = depth_q;
    assign bus.stackErr   = err_q;
endmodule

// File: tb/tb_cra_next_addr.sv
// Bench for cra_next_addr: directed scenarios with constant expectations plus a randomized
// run compared each cycle against a queue-based reference model.
module tb_cra_next_addr;
    localparam int unsigned SD = 16;
    localparam int unsigned AW = 11;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    cra_next_addr_if #(.STACK_DEPTH(SD), .ADR_W(AW)) bus ();

    cra_next_addr #(.STACK_DEPTH(SD), .ADR_W(AW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: address, sticky error, and the return stack as a queue.
    logic [AW-1:0] m_adr;
    logic          m_err;
    logic [AW-1:0] m_stack[$];

    task automatic model_edge();
        logic [AW-1:0] nxt;
        if (!resetN) begin
            m_adr = '0;
            m_err = 1'b0;
            m_stack.delete();
        end else if (bus.diagLoadAdr) begin
            m_adr = bus.diagAdr;
        end else if (bus.cramAdvance) begin
            case (bus.CRAM_DISP)
                3'd1: nxt = bus.DRAM_J;
                3'd2: nxt = bus.CRAM_J | {8'd0, bus.DRAM_A};
                3'd3: nxt = bus.CRAM_J | {8'd0, bus.DRAM_B};
                3'd4: nxt = bus.CRAM_J | {8'd0, bus.norm};
                3'd5: nxt = bus.CRAM_J | {10'd0, bus.testSatisfied};
                3'd6: begin
                    if (m_stack.size() == 0) begin
                        nxt   = bus.CRAM_J;
                        m_err = 1'b1;
                    end else begin
                        nxt = m_stack.pop_back() | bus.CRAM_J;
                    end
                end
                default: nxt = bus.CRAM_J;
            endcase
            if (bus.CRAM_CALL) begin
                if (m_stack.size() == SD) m_err = 1'b1;
                else m_stack.push_back(m_adr);
            end
            m_adr = nxt;
        end
    endtask

    // One clock: update model from pre-edge inputs, then sample #1 after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        resetN            = 1'b1;
        bus.cramAdvance   = 1'b0;
        bus.CRAM_J        = '0;
        bus.CRAM_DISP     = 3'd0;
        bus.CRAM_CALL     = 1'b0;
        bus.DRAM_J        = '0;
        bus.DRAM_A        = '0;
        bus.DRAM_B        = '0;
        bus.norm          = '0;
        bus.testSatisfied = 1'b0;
        bus.diagLoadAdr   = 1'b0;
        bus.diagAdr       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetN = 1'b0;
        cycle();
        resetN = 1'b1;
    endtask

    task automatic adv(input logic [2:0] disp, input logic [AW-1:0] j, input logic call);
        idle_inputs();
        bus.cramAdvance = 1'b1;
        bus.CRAM_DISP   = disp;
        bus.CRAM_J      = j;
        bus.CRAM_CALL   = call;
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.CRA_ADR !== 11'o0000 || bus.stackDepth !== 5'd0 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: adr=%o depth=%0d err=%b, want 0/0/0",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
    endtask

    task automatic test_jump();
        do_reset();
        adv(3'd0, 11'o1234, 1'b0);
        checks++;
        if (bus.CRA_ADR !== 11'o1234 || bus.stackDepth !== 5'd0 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL jump: adr=%o depth=%0d err=%b, want 1234/0/0",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
    endtask

    task automatic test_drama_and_hold();
        idle_inputs();
        bus.cramAdvance = 1'b1;
        bus.CRAM_DISP   = 3'd2;
        bus.CRAM_J      = 11'o0140;
        bus.DRAM_A      = 3'b101;
        cycle();
        checks++;
        if (bus.CRA_ADR !== 11'o0145) begin
            errors++;
            $display("FAIL drama: adr=%o want 0145", bus.CRA_ADR);
        end
        bus.cramAdvance = 1'b0;
        bus.CRAM_J      = 11'o0777;
        cycle();
        checks++;
        if (bus.CRA_ADR !== 11'o0145) begin
            errors++;
            $display("FAIL hold: adr=%o want 0145", bus.CRA_ADR);
        end
        idle_inputs();
    endtask

    task automatic test_call_return();
        do_reset();
        adv(3'd0, 11'o0200, 1'b0);
        adv(3'd0, 11'o0500, 1'b1);
        checks++;
        if (bus.CRA_ADR !== 11'o0500 || bus.stackDepth !== 5'd1) begin
            errors++;
            $display("FAIL call: adr=%o depth=%0d, want 0500/1", bus.CRA_ADR, bus.stackDepth);
        end
        adv(3'd6, 11'o0002, 1'b0);
        checks++;
        if (bus.CRA_ADR !== 11'o0202 || bus.stackDepth !== 5'd0 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL return: adr=%o depth=%0d err=%b, want 0202/0/0",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 16; k++) adv(3'd0, 11'(k), 1'b1);
        checks++;
        if (bus.stackDepth !== 5'd16 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL fill16: depth=%0d err=%b, want 16/0", bus.stackDepth, bus.stackErr);
        end
        adv(3'd0, 11'd17, 1'b1);
        checks++;
        if (bus.stackDepth !== 5'd16 || bus.stackErr !== 1'b1 || bus.CRA_ADR !== 11'd17) begin
            errors++;
            $display("FAIL overflow: depth=%0d err=%b adr=%o, want 16/1/21",
                     bus.stackDepth, bus.stackErr, bus.CRA_ADR);
        end
        // Dropped push must not have clobbered the top (address 15 was pushed last).
        adv(3'd6, 11'o0000, 1'b0);
        checks++;
        if (bus.CRA_ADR !== 11'd15 || bus.stackDepth !== 5'd15) begin
            errors++;
            $display("FAIL overflow_top: adr=%0d depth=%0d, want 15/15",
                     bus.CRA_ADR, bus.stackDepth);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        adv(3'd6, 11'o0007, 1'b0);
        checks++;
        if (bus.CRA_ADR !== 11'o0007 || bus.stackDepth !== 5'd0 || bus.stackErr !== 1'b1) begin
            errors++;
            $display("FAIL underflow: adr=%o depth=%0d err=%b, want 0007/0/1",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
        adv(3'd0, 11'o0010, 1'b0);
        checks++;
        if (bus.stackErr !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b want 1", bus.stackErr);
        end
    endtask

    task automatic test_call_and_return();
        do_reset();
        adv(3'd0, 11'o0100, 1'b0);
        adv(3'd0, 11'o0300, 1'b1);
        adv(3'd0, 11'o0410, 1'b1);
        adv(3'd6, 11'o0000, 1'b1);
        checks++;
        if (bus.CRA_ADR !== 11'o0300 || bus.stackDepth !== 5'd2) begin
            errors++;
            $display("FAIL call_ret: adr=%o depth=%0d, want 0300/2", bus.CRA_ADR, bus.stackDepth);
        end
        adv(3'd6, 11'o0000, 1'b0);
        checks++;
        if (bus.CRA_ADR !== 11'o0410 || bus.stackDepth !== 5'd1) begin
            errors++;
            $display("FAIL call_ret_top: adr=%o depth=%0d, want 0410/1",
                     bus.CRA_ADR, bus.stackDepth);
        end
        adv(3'd6, 11'o0000, 1'b0);
        checks++;
        if (bus.CRA_ADR !== 11'o0100 || bus.stackDepth !== 5'd0 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL call_ret_bottom: adr=%o depth=%0d err=%b, want 0100/0/0",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
        // Call+return on an empty stack: underflow flagged, push still lands.
        adv(3'd0, 11'o0020, 1'b0);
        adv(3'd6, 11'o0004, 1'b1);
        checks++;
        if (bus.CRA_ADR !== 11'o0004 || bus.stackDepth !== 5'd1 || bus.stackErr !== 1'b1) begin
            errors++;
            $display("FAIL call_ret_empty: adr=%o depth=%0d err=%b, want 0004/1/1",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
    endtask

    task automatic test_diag_precedence();
        do_reset();
        adv(3'd0, 11'o0050, 1'b1);
        idle_inputs();
        bus.cramAdvance = 1'b1;
        bus.CRAM_CALL   = 1'b1;
        bus.CRAM_DISP   = 3'd6;
        bus.CRAM_J      = 11'o0001;
        bus.diagLoadAdr = 1'b1;
        bus.diagAdr     = 11'o3777;
        cycle();
        idle_inputs();
        checks++;
        if (bus.CRA_ADR !== 11'o3777 || bus.stackDepth !== 5'd1 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL diag: adr=%o depth=%0d err=%b, want 3777/1/0",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
    endtask

    task automatic test_reset_precedence();
        adv(3'd6, 11'o0007, 1'b0);
        adv(3'd6, 11'o0007, 1'b0);
        idle_inputs();
        resetN          = 1'b0;
        bus.cramAdvance = 1'b1;
        bus.CRAM_CALL   = 1'b1;
        bus.CRAM_J      = 11'o0555;
        cycle();
        idle_inputs();
        checks++;
        if (bus.CRA_ADR !== 11'o0000 || bus.stackDepth !== 5'd0 || bus.stackErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_prec: adr=%o depth=%0d err=%b, want 0/0/0",
                     bus.CRA_ADR, bus.stackDepth, bus.stackErr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            resetN            = ($urandom_range(0, 99) != 0);
            bus.cramAdvance   = ($urandom_range(0, 9) < 8);
            bus.diagLoadAdr   = ($urandom_range(0, 29) == 0);
            bus.diagAdr       = 11'($urandom);
            bus.CRAM_DISP     = 3'($urandom);
            bus.CRAM_CALL     = ($urandom_range(0, 9) < 4);
            bus.CRAM_J        = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'($urandom & 8);
            bus.DRAM_J        = 11'($urandom);
            bus.DRAM_A        = 3'($urandom);
            bus.DRAM_B        = 3'($urandom);
            bus.norm          = 3'($urandom);
            bus.testSatisfied = 1'($urandom);
            cycle();
            checks++;
            if (bus.CRA_ADR !== m_adr || bus.stackDepth !== 5'(m_stack.size())
                || bus.stackErr !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: adr=%o depth=%0d err=%b, want %o/%0d/%b", n,
                         bus.CRA_ADR, bus.stackDepth, bus.stackErr,
                         m_adr, m_stack.size(), m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_adr = '0;
        m_err = 1'b0;
        test_reset();
        test_jump();
        test_drama_and_hold();
        test_call_return();
        test_overflow();
        test_underflow();
        test_call_and_return();
        test_diag_precedence();
        test_reset_precedence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cra_next_addr.md
Name: cra_next_addr

Overview:
- Control-RAM next-address stage, directly downstream of the IR board.
- Consumes the IR board's dispatch outputs (DRAM_J, DRAM_A, DRAM_B, norm, testSatisfied) plus the current microword's J and dispatch fields.
- Forms and registers the next CRAM address.
- Holds a microcode subroutine call/return stack.

Parameters:
- STACK_DEPTH, 16, number of return-address entries; must be a power of 2.
- ADR_W, 11, CRAM address width.

Ports:
- clk  input  1  system clock.
- resetN  input  1  synchronous, active-low reset.
- cramAdvance  input  1  strobe: load the next address this cycle.
- CRAM_J  input  ADR_W  jump field of the current microword.
- CRAM_DISP  input  3  dispatch select. 0 JUMP, 1 DRAMJ, 2 DRAMA, 3 DRAMB, 4 NORM, 5 TEST, 6 RETURN, 7 reserved (treated as JUMP).
- CRAM_CALL  input  1  push a return address on this advance.
- DRAM_J  input  ADR_W  DRAM J field from IR.
- DRAM_A  input  3  DRAM A field from IR.
- DRAM_B  input  3  DRAM B field from IR.
- norm  input  3  normalize priority code from IR.
- testSatisfied  input  1  skip condition from IR.
- diagLoadAdr  input  1  diagnostic force-load of the address.
- diagAdr  input  ADR_W  diagnostic address value.
- CRA_ADR  output  ADR_W  registered current CRAM address.
- stackDepth  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stackErr  output  1  sticky flag: overflow or underflow occurred.

Behaviour:
- All state changes on posedge clk only. Priority: reset > diagLoadAdr > cramAdvance.
- Reset (resetN=0 at an edge):
  - CRA_ADR=0, stackDepth=0, stackErr=0.
  - Stack contents are don't-care.
  - Reset overrides any in-flight call or return.
- diagLoadAdr=1: CRA_ADR<=diagAdr. Stack and stackErr are unchanged, even if cramAdvance=1.
- No strobe (cramAdvance=0, diagLoadAdr=0): every register holds.
- Advance: next address computed combinationally from inputs sampled at the edge; CRA_ADR updates at that edge (1-cycle latency). Address by CRAM_DISP:
  - JUMP (0 and 7): CRAM_J.
  - DRAMJ: DRAM_J. Full replace; CRAM_J ignored.
  - DRAMA: CRAM_J with DRAM_A OR'd into bits [2:0].
  - DRAMB: CRAM_J with DRAM_B OR'd into bits [2:0].
  - NORM: CRAM_J with norm OR'd into bits [2:0].
  - TEST: CRAM_J with testSatisfied OR'd into bit 0.
  - RETURN: top-of-stack OR'd with CRAM_J. Pops one entry.
- Underflow: RETURN with stackDepth=0.
  - Address = CRAM_J. Depth stays 0. stackErr<=1.
- Call: CRAM_CALL=1 on an advance pushes the current CRA_ADR (the calling word's address), not the new one. Depth increments.
- Overflow: push with stackDepth=STACK_DEPTH.
  - No write; depth unchanged; stackErr<=1.
  - Address computation proceeds normally.
- CALL and RETURN on the same advance:
  - Pop first (supplies the address), then push current CRA_ADR into the freed slot.
  - Net depth unchanged; top entry replaced.
  - If depth=0: underflow is flagged and the push still proceeds, so depth becomes 1.
- Stack storage: register array indexed by depth-1. No wrap-around; entries beyond depth are never read.
- stackErr clears only on reset.
- Address arithmetic is pure OR; there is no carry or increment anywhere.

Test Plan:
- Reset, then JUMP to CRAM_J=0o1234 with advance -> CRA_ADR=0o1234 next cycle; stackDepth=0; stackErr=0.
- DRAMA dispatch with CRAM_J=0o0140, DRAM_A=3'b101 -> CRA_ADR=0o0145. Same setup with advance=0 -> CRA_ADR holds its prior value.
- Call then return:
  - At CRA_ADR=0o0200, advance with CALL=1, JUMP to 0o0500 -> CRA_ADR=0o0500, depth=1.
  - Then RETURN with CRAM_J=0o0002 -> CRA_ADR=0o0202, depth=0.
- Overflow and underflow:
  - 17 consecutive CALL advances -> depth saturates at 16; stackErr=1 after the 17th.
  - Separately, from reset, RETURN with CRAM_J=0o0007 -> CRA_ADR=0o0007, stackErr=1.
- Simultaneous CALL+RETURN at depth=2, top=0o0300, CRA_ADR=0o0410, CRAM_J=0 -> CRA_ADR=0o0300, depth=2, new top=0o0410.
- Precedence checks:
  - diagLoadAdr=1 with diagAdr=0o3777 and cramAdvance=1 CALL -> CRA_ADR=0o3777, depth unchanged.
  - resetN=0 asserted together with CALL -> all outputs 0.
